// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: FSM state
// encoding and the mem_sel encoding for the shared address/data mux.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // mem_sel values: which requester currently owns the memory port
    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// Parameterised 2:1 mux, one bit slice per generate iteration.
// sel = 0 passes a, sel = 1 passes b.
module mem_port_arbiter_mux2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign y[gi] = sel ? b[gi] : a[gi];
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU's single memory port between instruction fetch (IF)
// and the MEM-stage data requester. Data wins by default; a starvation
// counter forces a fetch after STARVE_LIMIT consecutive data grants while a
// fetch is waiting. All memory-side outputs are registered and held stable
// for the whole access. if_flush cancels the fetch result, never the
// memory transaction itself.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    // instruction fetch side
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    // data access side
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    // external memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_sel
);

    localparam int unsigned         BE_W  = DATA_W / 8;
    localparam int unsigned         CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t          state_reg,      state_next;
    logic [CNT_W-1:0]    starve_cnt_reg, starve_cnt_next;
    logic                flush_pend_reg, flush_pend_next;
    logic                mem_req_reg,    mem_req_next;
    logic                mem_we_reg,     mem_we_next;
    logic [ADDR_W-1:0]   mem_addr_reg,   mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_reg,  mem_wdata_next;
    logic [BE_W-1:0]     mem_be_reg,     mem_be_next;
    logic                mem_sel_reg,    mem_sel_next;
    logic                if_ack_reg,     if_ack_next;
    logic [DATA_W-1:0]   if_rdata_reg,   if_rdata_next;
    logic                d_ack_reg,      d_ack_next;
    logic [DATA_W-1:0]   d_rdata_reg,    d_rdata_next;

    logic                grant_d;
    logic                grant_i;
    logic                addr_sel;
    logic [ADDR_W-1:0]   grant_addr;

    // IDLE arbitration: data first unless a waiting fetch has been starved
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_reg == IDLE) begin
            grant_d = d_req && (!if_req || (starve_cnt_reg < LIMIT));
            grant_i = !grant_d && if_req && !if_flush;
        end
    end

    assign addr_sel = grant_d ? SEL_D : SEL_IF;

    // address capture path: picks the granted requester's address
    mem_port_arbiter_mux2 #(
        .WIDTH (ADDR_W)
    ) u_addr_mux (
        .sel (addr_sel),
        .a   (if_addr),
        .b   (d_addr),
        .y   (grant_addr)
    );

    // next-state and registered-output logic for the access sequencer
    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        flush_pend_next = flush_pend_reg;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_be_next     = mem_be_reg;
        mem_sel_next    = mem_sel_reg;
        if_ack_next     = 1'b0;
        if_rdata_next   = if_rdata_reg;
        d_ack_next      = 1'b0;
        d_rdata_next    = d_rdata_reg;

        case (state_reg)
            IDLE: begin
                flush_pend_next = 1'b0;
                if (grant_d) begin
                    state_next     = BUSY_D;
                    mem_req_next   = 1'b1;
                    mem_sel_next   = SEL_D;
                    mem_addr_next  = grant_addr;
                    mem_wdata_next = d_wdata;
                    mem_be_next    = d_be;
                    mem_we_next    = d_we;
                    // count data grants only while a fetch is actually waiting
                    if (!if_req) begin
                        starve_cnt_next = '0;
                    end else if (starve_cnt_reg != LIMIT) begin
                        starve_cnt_next = starve_cnt_reg + CNT_W'(1);
                    end
                end else if (grant_i) begin
                    state_next      = BUSY_I;
                    mem_req_next    = 1'b1;
                    mem_sel_next    = SEL_IF;
                    mem_addr_next   = grant_addr;
                    mem_wdata_next  = '0;
                    mem_be_next     = '1;   // fetches read the full word
                    mem_we_next     = 1'b0;
                    starve_cnt_next = '0;
                end else if (!if_req) begin
                    starve_cnt_next = '0;
                end
            end

            BUSY_I: begin
                if (if_flush) begin
                    flush_pend_next = 1'b1;
                end
                if (mem_ready) begin
                    state_next      = IDLE;
                    mem_req_next    = 1'b0;
                    flush_pend_next = 1'b0;
                    // a redirect during the access discards the fetched word
                    if (!flush_pend_reg && !if_flush) begin
                        if_rdata_next = mem_rdata;
                        if_ack_next   = 1'b1;
                    end
                end
            end

            BUSY_D: begin
                if (mem_ready) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    d_rdata_next = mem_rdata;
                    d_ack_next   = 1'b1;
                end
            end

            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    // state and output registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            flush_pend_reg <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_be_reg     <= '0;
            mem_sel_reg    <= SEL_IF;
            if_ack_reg     <= 1'b0;
            if_rdata_reg   <= '0;
            d_ack_reg      <= 1'b0;
            d_rdata_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            flush_pend_reg <= flush_pend_next;
            mem_req_reg    <= mem_req_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_be_reg     <= mem_be_next;
            mem_sel_reg    <= mem_sel_next;
            if_ack_reg     <= if_ack_next;
            if_rdata_reg   <= if_rdata_next;
            d_ack_reg      <= d_ack_next;
            d_rdata_reg    <= d_rdata_next;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_be    = mem_be_reg;
    assign mem_sel   = mem_sel_reg;
    assign if_ack    = if_ack_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_ack     = d_ack_reg;
    assign d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for single fetch and
// collision, then hand sequences for starvation, flush, wait-state hold and
// asynchronous reset mid-access.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_req, mem_we, mem_ready, mem_sel;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] STARVE_RD = 32'h5555_AAAA;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (32), .DATA_W (32), .STARVE_LIMIT (4)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .if_req (if_req), .if_addr (if_addr), .if_flush (if_flush),
        .if_ack (if_ack), .if_rdata (if_rdata),
        .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
        .d_be (d_be), .d_ack (d_ack), .d_rdata (d_rdata),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_be (mem_be), .mem_ready (mem_ready),
        .mem_rdata (mem_rdata), .mem_sel (mem_sel)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        if_flush;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        e_mem_req;
        logic        e_mem_sel;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic        chk_wd;
        logic [31:0] e_mem_wdata;
        logic [3:0]  e_mem_be;
        logic        e_if_ack;
        logic        e_d_ack;
        logic [31:0] e_if_rdata;
        logic [31:0] e_d_rdata;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    // watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int grants;
        logic prev_req;

        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        step();

        // ---- reset state ----
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_sel", {31'd0, mem_sel}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);

        // ---- vector table: single fetch then collision ----
        //          ifr if_addr  fl dr dwe d_addr    d_wdata       be    rdy rdata         | req sel we addr   cw wdata        be    ia da if_rdata      d_rdata
        vecs[0]  = '{1, 32'h40,  0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,         1, 0, 0, 32'h40, 0, 32'h0,        4'h0, 0, 0, 32'h0,        32'h0};
        vecs[1]  = '{1, 32'h40,  0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,         1, 0, 0, 32'h40, 0, 32'h0,        4'h0, 0, 0, 32'h0,        32'h0};
        vecs[2]  = '{1, 32'h40,  0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,         1, 0, 0, 32'h40, 0, 32'h0,        4'h0, 0, 0, 32'h0,        32'h0};
        vecs[3]  = '{1, 32'h40,  0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,         1, 0, 0, 32'h40, 0, 32'h0,        4'h0, 0, 0, 32'h0,        32'h0};
        vecs[4]  = '{1, 32'h40,  0, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h2408_0005, 0, 0, 0, 32'h40, 0, 32'h0,        4'h0, 1, 0, 32'h2408_0005, 32'h0};
        vecs[5]  = '{0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,         0, 0, 0, 32'h40, 0, 32'h0,        4'h0, 0, 0, 32'h2408_0005, 32'h0};
        vecs[6]  = '{1, 32'h80,  0, 1, 1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,        1, 1, 1, 32'h100, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h2408_0005, 32'h0};
        vecs[7]  = '{1, 32'h80,  0, 1, 1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1, 32'h1234_5678, 0, 1, 1, 32'h100, 1, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'h2408_0005, 32'h1234_5678};
        vecs[8]  = '{1, 32'h80,  0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,         1, 0, 0, 32'h80, 0, 32'h0,        4'h0, 0, 0, 32'h2408_0005, 32'h1234_5678};
        vecs[9]  = '{1, 32'h80,  0, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'hCAFE_0001, 0, 0, 0, 32'h80, 0, 32'h0,        4'h0, 1, 0, 32'hCAFE_0001, 32'h1234_5678};
        vecs[10] = '{0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,         0, 0, 0, 32'h80, 0, 32'h0,        4'h0, 0, 0, 32'hCAFE_0001, 32'h1234_5678};

        for (int i = 0; i < 11; i++) begin
            if_req = vecs[i].if_req;   if_addr = vecs[i].if_addr; if_flush = vecs[i].if_flush;
            d_req = vecs[i].d_req;     d_we = vecs[i].d_we;       d_addr = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata; d_be = vecs[i].d_be;
            mem_ready = vecs[i].mem_ready; mem_rdata = vecs[i].mem_rdata;
            step();
            $display("vec %0d: mem_req=%0b sel=%0b we=%0b addr=0x%08h if_ack=%0b d_ack=%0b",
                     i, mem_req, mem_sel, mem_we, mem_addr, if_ack, d_ack);
            chk($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_mem_req});
            chk($sformatf("v%0d_mem_sel", i), {31'd0, mem_sel}, {31'd0, vecs[i].e_mem_sel});
            chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_mem_we});
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_mem_addr);
            chk($sformatf("v%0d_if_ack", i), {31'd0, if_ack}, {31'd0, vecs[i].e_if_ack});
            chk($sformatf("v%0d_d_ack", i), {31'd0, d_ack}, {31'd0, vecs[i].e_d_ack});
            chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_if_rdata);
            chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_d_rdata);
            if (vecs[i].chk_wd) begin
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
                chk($sformatf("v%0d_mem_be", i), {28'd0, mem_be}, {28'd0, vecs[i].e_mem_be});
            end
        end

        // ---- starvation: both requesters held, 0-wait memory ----
        if_req = 1; if_addr = 32'h700;
        d_req = 1; d_we = 0; d_addr = 32'h800;
        mem_ready = 1; mem_rdata = STARVE_RD;
        grants = 0;
        prev_req = mem_req;
        for (int cyc = 0; cyc < 60 && grants < 10; cyc++) begin
            step();
            if (mem_req && !prev_req) begin
                $display("starve grant %0d: mem_sel=%0b", grants, mem_sel);
                chk($sformatf("starve_grant%0d_sel", grants), {31'd0, mem_sel},
                    (grants % 5 == 4) ? 32'd0 : 32'd1);
                grants++;
            end
            prev_req = mem_req;
        end
        checks++;
        if (grants < 10) begin
            errors++;
            $display("FAIL starve_grant_count: got %0d expected 10", grants);
        end
        if_req = 0; d_req = 0;
        step();                 // last grant (IF) completes
        mem_ready = 0;
        step();
        chk("starve_if_rdata", if_rdata, STARVE_RD);

        // ---- flush in flight ----
        if_req = 1; if_addr = 32'h200;
        step();
        $display("flush: IF granted mem_req=%0b sel=%0b", mem_req, mem_sel);
        chk("flush_grant_req", {31'd0, mem_req}, 32'd1);
        chk("flush_grant_sel", {31'd0, mem_sel}, 32'd0);
        if_flush = 1; if_req = 0;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        step();
        chk("flush_req_held1", {31'd0, mem_req}, 32'd1);
        if_flush = 0;
        step();
        chk("flush_req_held2", {31'd0, mem_req}, 32'd1);
        mem_ready = 1; mem_rdata = 32'hBAD0_0BAD;
        step();
        chk("flush_req_drop", {31'd0, mem_req}, 32'd0);
        chk("flush_no_if_ack", {31'd0, if_ack}, 32'd0);
        chk("flush_if_rdata", if_rdata, STARVE_RD);
        mem_ready = 0;
        step();
        $display("flush: next grant sel=%0b addr=0x%08h", mem_sel, mem_addr);
        chk("flush_d_grant_req", {31'd0, mem_req}, 32'd1);
        chk("flush_d_grant_sel", {31'd0, mem_sel}, 32'd1);
        chk("flush_d_grant_addr", mem_addr, 32'h300);
        chk("flush_no_if_ack2", {31'd0, if_ack}, 32'd0);
        mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
        step();
        chk("flush_d_ack", {31'd0, d_ack}, 32'd1);
        chk("flush_d_rdata", d_rdata, 32'h0BAD_F00D);
        d_req = 0; mem_ready = 0;
        step();

        // ---- wait-state hold: 10 cycles with changing inputs ----
        d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h1111_2222; d_be = 4'b0011;
        step();
        for (int k = 0; k < 10; k++) begin
            d_addr = 32'h900 + 32'(k); d_wdata = 32'hF0F0_0000 + 32'(k);
            d_be = 4'b1100; d_we = k[0];
            step();
            $display("hold %0d: addr=0x%08h wdata=0x%08h be=%h we=%0b", k, mem_addr, mem_wdata, mem_be, mem_we);
            chk($sformatf("hold%0d_req", k), {31'd0, mem_req}, 32'd1);
            chk($sformatf("hold%0d_addr", k), mem_addr, 32'h400);
            chk($sformatf("hold%0d_wdata", k), mem_wdata, 32'h1111_2222);
            chk($sformatf("hold%0d_be", k), {28'd0, mem_be}, 32'h3);
            chk($sformatf("hold%0d_we", k), {31'd0, mem_we}, 32'd1);
        end
        mem_ready = 1; mem_rdata = 32'h0;
        step();
        chk("hold_d_ack", {31'd0, d_ack}, 32'd1);
        d_req = 0; mem_ready = 0;
        step();

        // ---- asynchronous reset mid-access ----
        d_req = 1; d_we = 1; d_addr = 32'h500; d_wdata = 32'h7777_7777; d_be = 4'hF;
        step();
        chk("rstmid_busy_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 0;
        #1;
        $display("reset mid-access: mem_req=%0b sel=%0b addr=0x%08h", mem_req, mem_sel, mem_addr);
        chk("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstmid_mem_sel", {31'd0, mem_sel}, 32'd0);
        chk("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rstmid_mem_addr", mem_addr, 32'd0);
        chk("rstmid_mem_wdata", mem_wdata, 32'd0);
        chk("rstmid_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rstmid_if_rdata", if_rdata, 32'd0);
        chk("rstmid_d_rdata", d_rdata, 32'd0);
        chk("rstmid_acks", {30'd0, if_ack, d_ack}, 32'd0);
        idle_inputs();
        step();
        step();
        rst_n = 1;
        mem_ready = 1; mem_rdata = 32'hEEEE_EEEE;
        step();
        chk("spurious_d_ack", {31'd0, d_ack}, 32'd0);
        chk("spurious_if_ack", {31'd0, if_ack}, 32'd0);
        chk("spurious_mem_req", {31'd0, mem_req}, 32'd0);
        chk("spurious_d_rdata", d_rdata, 32'd0);
        mem_ready = 0;
        if_req = 1; if_addr = 32'h600;
        step();
        chk("post_rst_req", {31'd0, mem_req}, 32'd1);
        chk("post_rst_sel", {31'd0, mem_sel}, 32'd0);
        chk("post_rst_addr", mem_addr, 32'h600);
        mem_ready = 1; mem_rdata = 32'h600D_0600;
        step();
        $display("post-reset fetch: if_ack=%0b if_rdata=0x%08h", if_ack, if_rdata);
        chk("post_rst_if_ack", {31'd0, if_ack}, 32'd1);
        chk("post_rst_if_rdata", if_rdata, 32'h600D_0600);
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
